// File: rtl/ex_div_if.sv
// Handshake bundle between the ID/EX register, the EX-stage divider and the EX->MEM write-back path.
interface ex_div_if #(parameter int XLEN = 32);
  logic            start_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic [4:0]      rd_addr_i;
  logic            flush_i;
  logic            stall_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_addr_o;

  modport master (
    output start_i, funct3_i, op1_i, op2_i, rd_addr_i, flush_i,
    input  stall_o, valid_o, result_o, rd_addr_o
  );

  modport slave (
    input  start_i, funct3_i, op1_i, op2_i, rd_addr_i, flush_i,
    output stall_o, valid_o, result_o, rd_addr_o
  );
endinterface

// File: rtl/ex_div.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring, one quotient bit per cycle.
// Optional: define DIV_EARLY_TERM_EN to finish in one cycle when |dividend| < |divisor|.
module ex_div #(
  parameter int XLEN = 32
) (
  input  logic clk,
  input  logic rstn,
  ex_div_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_q, rd_d;
  logic            is_rem_q, is_rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            raw_q, raw_d;

  logic            is_signed, op1_neg, op2_neg, div_zero, overflow, early;
  logic [XLEN-1:0] op1_mag, op2_mag, diff, final_res;
  logic [XLEN:0]   shifted;
  logic            fits;

  always_comb begin
    is_signed = ~bus.funct3_i[0];
    op1_neg   = is_signed & bus.op1_i[XLEN-1];
    op2_neg   = is_signed & bus.op2_i[XLEN-1];
    op1_mag   = op1_neg ? -bus.op1_i : bus.op1_i;
    op2_mag   = op2_neg ? -bus.op2_i : bus.op2_i;
    div_zero  = (bus.op2_i == '0);
    overflow  = is_signed && (bus.op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op2_i == '1);
`ifdef DIV_EARLY_TERM_EN
    early     = !div_zero && (op1_mag < op2_mag);
`else
    early     = 1'b0;
`endif
    // One restoring step: the shifted partial remainder may need XLEN+1 bits.
    shifted   = {rem_q, quo_q[XLEN-1]};
    fits      = (shifted >= {1'b0, dvs_q});
    diff      = shifted[XLEN-1:0] - dvs_q;
    if (raw_q)          final_res = is_rem_q ? rem_q : quo_q;
    else if (is_rem_q)  final_res = neg_rem_q ? -rem_q : rem_q;
    else                final_res = neg_quo_q ? -quo_q : quo_q;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    result_d    = result_q;
    rd_d        = rd_q;
    is_rem_d    = is_rem_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    raw_d       = raw_q;
    bus.stall_o = 1'b0;
    bus.valid_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start_i && bus.funct3_i[2] && !bus.flush_i) begin
          bus.stall_o = 1'b1;
          rd_d        = bus.rd_addr_i;
          is_rem_d    = bus.funct3_i[1];
          neg_quo_d   = op1_neg ^ op2_neg;
          neg_rem_d   = op1_neg;
          raw_d       = 1'b1;
          state_d     = DONE;
          if (div_zero) begin
            quo_d = '1;
            rem_d = bus.op1_i;
          end else if (overflow) begin
            quo_d = bus.op1_i;
            rem_d = '0;
          end else if (early) begin
            quo_d = '0;
            rem_d = bus.op1_i;
          end else begin
            quo_d   = op1_mag;
            rem_d   = '0;
            dvs_d   = op2_mag;
            raw_d   = 1'b0;
            count_d = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        bus.stall_o = 1'b1;
        rem_d       = fits ? diff : shifted[XLEN-1:0];
        quo_d       = {quo_q[XLEN-2:0], fits};
        if (count_q == CW'(XLEN-1)) begin
          count_d = '0;
          state_d = DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      DONE: begin
        bus.valid_o = 1'b1;
        result_d    = final_res;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A flush wins over everything, including a result about to be strobed.
    if (bus.flush_i) begin
      state_d     = IDLE;
      count_d     = '0;
      bus.valid_o = 1'b0;
      result_d    = result_q;
    end
  end

  assign bus.result_o  = bus.valid_o ? final_res : result_q;
  assign bus.rd_addr_o = rd_q;

  // NOTE: sequential state uses non-blocking assignments only; the datapath registers are
  // reset too so result_o and rd_addr_o read zero straight out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      rd_q      <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      raw_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      rd_q      <= rd_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      raw_q     <= raw_d;
    end
  end
endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: reference model + scoreboard queue of expected write-backs.
module tb_ex_div;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb_q[$];

  ex_div_if #(.XLEN(32)) bus ();

  ex_div #(.XLEN(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f[1:0])
      2'b00:   return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    ma = (!f[0] && a[31]) ? -a : a;
    mb = (!f[0] && b[31]) ? -b : b;
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_TERM_EN
    if (ma < mb) return 1;
`else
    if (ma < mb) return 33;
`endif
    return 33;
  endfunction

  // Called at a negedge; drives the op for cycle T and returns at the negedge of the DONE cycle.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input string name);
    exp_t e;
    int   lat, stall_gaps;
    bit   got;
    sb_q.push_back('{model_res(f, a, b), rd, model_lat(f, a, b)});
    bus.start_i = 1'b1; bus.funct3_i = f; bus.op1_i = a; bus.op2_i = b; bus.rd_addr_i = rd;
    #1;
    vectors++;
    if (bus.stall_o !== 1'b1) begin
      miscompares++;
      $display("FAIL %s stall_at_T got %b want 1", name, bus.stall_o);
    end
    lat = 0; got = 0; stall_gaps = 0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.valid_o === 1'b1) got = 1;
      else if (bus.stall_o !== 1'b1) stall_gaps++;
    end
    bus.start_i = 1'b0;
    e = sb_q.pop_front();
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL %s timeout got no valid_o want valid after %0d cycles", name, e.lat);
      return;
    end
    vectors++;
    if (lat != e.lat) begin
      miscompares++;
      $display("FAIL %s latency got %0d want %0d", name, lat, e.lat);
    end
    vectors++;
    if (bus.result_o !== e.res) begin
      miscompares++;
      $display("FAIL %s result got %h want %h", name, bus.result_o, e.res);
    end
    vectors++;
    if (bus.rd_addr_o !== e.rd) begin
      miscompares++;
      $display("FAIL %s rd_addr got %0d want %0d", name, bus.rd_addr_o, e.rd);
    end
    vectors++;
    if (stall_gaps != 0 || bus.stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s stall_shape got gaps=%0d done_stall=%b want gaps=0 done_stall=0",
               name, stall_gaps, bus.stall_o);
    end
  endtask

  task automatic check_hold(input logic [31:0] res, input logic [4:0] rd, input string name);
    @(negedge clk);
    vectors++;
    if (bus.valid_o !== 1'b0 || bus.result_o !== res || bus.rd_addr_o !== rd) begin
      miscompares++;
      $display("FAIL %s hold got v=%b r=%h rd=%0d want v=0 r=%h rd=%0d",
               name, bus.valid_o, bus.result_o, bus.rd_addr_o, res, rd);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.start_i = 1'b0; bus.funct3_i = 3'b0; bus.op1_i = '0; bus.op2_i = '0;
    bus.rd_addr_i = '0; bus.flush_i = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.stall_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.result_o !== '0 || bus.rd_addr_o !== '0) begin
      miscompares++;
      $display("FAIL reset_state got s=%b v=%b r=%h rd=%0d want all zero",
               bus.stall_o, bus.valid_o, bus.result_o, bus.rd_addr_o);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divide();
    logic [2:0]  f;
    logic [31:0] a, b;
    do_op(F_DIVU, 32'd100, 32'd7, 5'd5, "divu_100_7");
    check_hold(32'd14, 5'd5, "divu_100_7");
    do_op(F_DIV,  32'hFFFF_FFF9, 32'd2, 5'd6, "div_m7_2");      @(negedge clk);
    do_op(F_REM,  32'hFFFF_FFF9, 32'd2, 5'd7, "rem_m7_2");      @(negedge clk);
    do_op(F_REMU, 32'hFFFF_FFF9, 32'd2, 5'd8, "remu_big_2");    @(negedge clk);
    do_op(F_DIV,  32'd100, 32'hFFFF_FFF9, 5'd9, "div_100_m7");  @(negedge clk);
    do_op(F_REM,  32'd100, 32'hFFFF_FFF9, 5'd10, "rem_100_m7"); @(negedge clk);
    do_op(F_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd11, "divu_max_1");   @(negedge clk);
    do_op(F_DIV,  32'h8000_0000, 32'd2, 5'd12, "div_min_2");    @(negedge clk);
    do_op(F_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd13, "remu_max"); @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      f = {1'b1, 2'(i)};
      a = $urandom;
      b = (i < 4) ? $urandom : 32'($urandom_range(1, 1000));
      do_op(f, a, b, 5'(14 + i), "random");
      @(negedge clk);
    end
  endtask

  task automatic test_special();
    do_op(F_DIVU, 32'd5, 32'd0, 5'd1, "divu_by_0");            @(negedge clk);
    do_op(F_REM,  32'd5, 32'd0, 5'd2, "rem_by_0");             @(negedge clk);
    do_op(F_DIV,  32'hFFFF_FFFB, 32'd0, 5'd3, "div_neg_by_0"); @(negedge clk);
    do_op(F_REMU, 32'hFFFF_FFFB, 32'd0, 5'd4, "remu_by_0");    @(negedge clk);
    do_op(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd30, "div_ovf");
    check_hold(32'h8000_0000, 5'd30, "div_ovf");
    do_op(F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd31, "rem_ovf"); @(negedge clk);
  endtask

  task automatic test_early_term();
    do_op(F_DIVU, 32'd3, 32'd10, 5'd20, "divu_3_10");           @(negedge clk);
    do_op(F_REMU, 32'd3, 32'd10, 5'd21, "remu_3_10");           @(negedge clk);
    do_op(F_REM,  32'hFFFF_FFFD, 32'd10, 5'd22, "rem_m3_10");   @(negedge clk);
  endtask

  task automatic test_flush();
    bit saw_valid;
    bit saw_stall;
    bus.start_i = 1'b1; bus.funct3_i = F_DIVU; bus.op1_i = 32'd100; bus.op2_i = 32'd7; bus.rd_addr_i = 5'd3;
    repeat (10) @(negedge clk);
    bus.flush_i = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    bus.flush_i = 1'b0;
    #1;
    vectors++;
    if (bus.stall_o !== 1'b0 || bus.valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_calc got s=%b v=%b want s=0 v=0", bus.stall_o, bus.valid_o);
    end
    saw_valid = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.valid_o === 1'b1) saw_valid = 1;
    end
    vectors++;
    if (saw_valid) begin
      miscompares++;
      $display("FAIL flush_no_valid got valid_o=1 want none");
    end
    do_op(F_DIVU, 32'd9, 32'd3, 5'd4, "divu_9_3_after_flush");
    @(negedge clk);

    bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.funct3_i = F_DIVU; bus.op1_i = 32'd50; bus.op2_i = 32'd5;
    #1;
    vectors++;
    if (bus.stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_idle_stall got %b want 0", bus.stall_o);
    end
    @(negedge clk);
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    saw_stall = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.stall_o !== 1'b0 || bus.valid_o !== 1'b0) saw_stall = 1;
    end
    vectors++;
    if (saw_stall) begin
      miscompares++;
      $display("FAIL flush_idle_accept got activity want idle");
    end
  endtask

  task automatic test_back_to_back();
    do_op(F_DIVU, 32'd1000, 32'd10, 5'd24, "b2b_first");
    bus.start_i = 1'b1; bus.funct3_i = F_REMU; bus.op1_i = 32'd1001; bus.op2_i = 32'd10; bus.rd_addr_i = 5'd25;
    #1;
    vectors++;
    if (bus.stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_done_ignores_start got stall=%b want 0", bus.stall_o);
    end
    @(negedge clk);
    do_op(F_REMU, 32'd1001, 32'd10, 5'd25, "b2b_second");
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit active;
    bus.start_i = 1'b1; bus.funct3_i = F_DIVU; bus.op1_i = 32'd77; bus.op2_i = 32'd7; bus.rd_addr_i = 5'd9;
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    bus.start_i = 1'b0;
    #1;
    vectors++;
    if (bus.stall_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.result_o !== '0 || bus.rd_addr_o !== '0) begin
      miscompares++;
      $display("FAIL reset_mid got s=%b v=%b r=%h rd=%0d want all zero",
               bus.stall_o, bus.valid_o, bus.result_o, bus.rd_addr_o);
    end
    @(negedge clk);
    rstn = 1'b1;
    active = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.stall_o !== 1'b0 || bus.valid_o !== 1'b0) active = 1;
    end
    vectors++;
    if (active) begin
      miscompares++;
      $display("FAIL reset_mid_idle got activity want idle");
    end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_special();
    test_early_term();
    test_back_to_back();
    test_flush();
    do_op(F_DIVU, 32'd12345, 32'd11, 5'd15, "pre_reset");
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
